multiplier_controller: RTL

Control FSM for the sequential shift-add multiplier. It sits directly upstream of multiplier_counter, driving its do_preset/do_decrement and consuming its is_zero. It also sequences the operand registers and accumulator through one add/shift pair per multiplier bit, and exposes a start/busy/done handshake to the surrounding logic.

---
 rtl/multiplier_controller.sv | 66 ++++++
 1 files changed

// File: rtl/multiplier_controller.sv
// multiplier_controller: start/busy/done FSM sequencing one add/shift pair per multiplier bit
module multiplier_controller #(
  parameter int N = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic multiplier_lsb,
  input  logic is_zero,
  output logic busy,
  output logic done,
  output logic do_load,
  output logic do_clear_acc,
  output logic do_add,
  output logic do_shift,
  output logic do_preset,
  output logic do_decrement
);
  typedef enum logic [2:0] {IDLE, INIT, ADD, SHIFT, DONE} state_t;
  state_t state, nxt;
  if (N < 1) begin : g_bad_n
    $error("multiplier_controller: N must be >= 1");
  end
  // state register; reset wins over everything, including mid-run
  always_ff @(posedge clock)
    state <= reset ? IDLE : nxt;
  // next state and Moore/Mealy outputs; unreachable encodings fall back to IDLE
  always_comb begin
    nxt = IDLE;
    busy = 1'b0;
    done = 1'b0;
    do_load = 1'b0;
    do_clear_acc = 1'b0;
    do_add = 1'b0;
    do_shift = 1'b0;
    do_preset = 1'b0;
    do_decrement = 1'b0;
    case (state)
      IDLE: nxt = start ? INIT : IDLE;
      INIT: begin
        nxt = ADD;
        busy = 1'b1;
        do_load = 1'b1;
        do_clear_acc = 1'b1;
        do_preset = 1'b1;
      end
      ADD: begin
        nxt = SHIFT;
        busy = 1'b1;
        do_add = multiplier_lsb;
      end
      SHIFT: begin
        nxt = is_zero ? DONE : ADD;
        busy = 1'b1;
        do_shift = 1'b1;
        do_decrement = ~is_zero;
      end
      DONE: begin
        nxt = IDLE;
        busy = 1'b1;
        done = 1'b1;
      end
      default: nxt = IDLE;
    endcase
  end
endmodule
